// File: rtl/led_trail_pwm_if.sv
// Pin bundle for the LED trail PWM block.
// The driver side uses master; the block itself uses slave.
interface led_trail_pwm_if #(
  parameter int width = 8
);
  logic             ENABLE;
  logic             TICK;
  logic [width-1:0] LEDS_IN;
  logic [width-1:0] LEDS_PWM;
  logic             PWM_SYNC;

  modport master (
    output ENABLE,
    output TICK,
    output LEDS_IN,
    input  LEDS_PWM,
    input  PWM_SYNC
  );

  modport slave (
    input  ENABLE,
    input  TICK,
    input  LEDS_IN,
    output LEDS_PWM,
    output PWM_SYNC
  );
endinterface

// File: rtl/led_trail_pwm.sv
// LED trail: per-channel brightness that decays on TICK.
// Each brightness value drives a registered PWM output.
module led_trail_pwm #(
  parameter int width      = 8,
  parameter int pwm_bits   = 4,
  parameter int decay_step = 4
) (
  input  logic            CLK,
  input  logic            RSTn,
  led_trail_pwm_if.slave  bus
);
  typedef logic [pwm_bits-1:0] lvl_t;

  localparam lvl_t MAX  = '1;
  localparam lvl_t STEP = lvl_t'(decay_step);

  lvl_t                   cnt_q, cnt_d;
  lvl_t [width-1:0]       bright_q, bright_d;
  logic [width-1:0]       pwm_q, pwm_d;
  logic                   sync_q, sync_d;

  always_comb begin
    cnt_d    = cnt_q;
    bright_d = bright_q;
    pwm_d    = '0;
    sync_d   = 1'b0;
    if (bus.ENABLE) begin
      cnt_d  = cnt_q + lvl_t'(1);
      sync_d = (cnt_q == '0);
      for (int i = 0; i < width; i++) begin
        // MAX is forced solid so a freshly lit LED has no gap
        pwm_d[i] = (bright_q[i] == MAX) ||
                   (bright_q[i] > cnt_q);
        if (bus.LEDS_IN[i]) begin
          bright_d[i] = MAX;
        end else if (bus.TICK) begin
          bright_d[i] = (bright_q[i] > STEP) ?
                        bright_q[i] - STEP : '0;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt_q    <= '0;
      bright_q <= '0;
      pwm_q    <= '0;
      sync_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      bright_q <= bright_d;
      pwm_q    <= pwm_d;
      sync_q   <= sync_d;
    end
  end

  assign bus.LEDS_PWM = pwm_q;
  assign bus.PWM_SYNC = sync_q;
endmodule

// File: doc/led_trail_pwm.md
LED_TRAIL_PWM -- requirements
Module: led_trail_pwm

Interface
REQ-001 Parameter width, default 8: number of LED channels.
REQ-002 Parameter pwm_bits, default 4: brightness and PWM counter width; MAX = 2^pwm_bits-1.
REQ-003 Parameter decay_step, default 4: brightness decrement per TICK; legal range 1..MAX.
REQ-004 CLK  input  1  single clock; all state updates on the rising edge.
REQ-005 RSTn  input  1  asynchronous, active-low reset.
REQ-006 ENABLE  input  1  high = run; low = freeze all state and blank the outputs.
REQ-007 TICK  input  1  one-cycle pulse from the upstream prescaler terminal count; triggers one decay step.
REQ-008 LEDS_IN  input  width  LED position pattern from the upstream decoder; each bit is treated independently.
REQ-009 LEDS_PWM  output  width  registered PWM drive to the physical LEDs.
REQ-010 PWM_SYNC  output  1  registered one-cycle pulse marking the start of each PWM period.

Function
REQ-011 Internal pwm_cnt (pwm_bits wide) SHALL increment by 1 on each enabled clock and wrap from MAX to 0.
REQ-012 Each channel i SHALL hold a brightness[i] register that is pwm_bits wide.
REQ-013 On an enabled clock with LEDS_IN[i]=1, brightness[i] SHALL load MAX.
REQ-014 On an enabled clock with LEDS_IN[i]=0 and TICK=1, brightness[i] SHALL load max(brightness[i]-decay_step, 0), saturating at 0 with no wrap.
REQ-015 On an enabled clock with LEDS_IN[i]=0 and TICK=0, brightness[i] SHALL hold.
REQ-016 When LEDS_IN[i]=1 and TICK=1 in the same cycle, the load of MAX SHALL win over decay.
REQ-017 LEDS_IN values of all-zero or multi-hot SHALL be legal; each bit SHALL follow REQ-013..016 per channel.
REQ-018 On each enabled clock, LEDS_PWM[i] SHALL register 1 iff (brightness[i]==MAX) or (brightness[i] > pwm_cnt), using the pre-edge values.
REQ-019 Duty cycle per channel SHALL therefore be: MAX -> 100%, 0 -> 0%, otherwise b/2^pwm_bits.
REQ-020 Latency from a LEDS_IN or TICK edge sample to the first affected LEDS_PWM value SHALL be 2 clocks.
REQ-021 On each enabled clock, PWM_SYNC SHALL register 1 iff pwm_cnt==0 before the edge; it is high for exactly 1 cycle per 2^pwm_bits enabled cycles.
REQ-022 While ENABLE=0, the following SHALL apply:
- pwm_cnt and all brightness[i] hold;
- TICK and LEDS_IN are ignored (a TICK arriving then is lost);
- LEDS_PWM and PWM_SYNC register 0 at the next edge.
REQ-023 When ENABLE returns to 1, pwm_cnt SHALL continue from its held value with no restart.
REQ-024 The block SHALL contain no combinational path from inputs to outputs.

Reset
REQ-025 RSTn=0 SHALL immediately, without waiting for a clock edge, clear:
- pwm_cnt to 0;
- all brightness[i] to 0;
- LEDS_PWM to 0;
- PWM_SYNC to 0.
REQ-026 An assertion of RSTn mid-period SHALL abort the current period; after release, the first enabled edge SHALL see pwm_cnt=0, so PWM_SYNC=1 one clock after release.
REQ-027 After reset release, all LEDs SHALL stay dark until a LEDS_IN bit is set.

Verification
REQ-028 Reset release, ENABLE=1, LEDS_IN=8'b10000000 held -> LEDS_PWM[7]=1 continuously from the 2nd clock; all other bits 0; PWM_SYNC every 16 clocks.
REQ-029 From REQ-028 state, LEDS_IN=8'b01000000 with one TICK -> brightness[7]=11, LEDS_PWM[7] high 11 of 16 cycles; after further TICKs, 7/16, then 3/16, then 0/16.
REQ-030 Channel at brightness 3, two TICKs -> brightness 0 then stays 0 (no wrap to 15); LEDS_PWM[i] never high.
REQ-031 LEDS_IN[3]=1 coincident with TICK at brightness[3]=7 -> brightness[3]=15 and LEDS_PWM[3] solid high.
REQ-032 ENABLE low for 5 clocks at pwm_cnt=6 with a TICK inside that window -> outputs 0 within 1 clock, brightness unchanged, TICK lost; on resume, pwm_cnt continues at 6.
REQ-033 RSTn pulsed low mid-period between clock edges -> LEDS_PWM=0 and PWM_SYNC=0 before the next edge; PWM_SYNC=1 one clock after release.
